// File: rtl/usb_rx_frame_mover.sv
// Moves one validated frame from USB RX RAM into USB data RAM, then releases the RX buffer and raises irq.
// Optional trailing-checksum verification is enabled by defining USB_FRAME_CHECKSUM_EN.
module usb_rx_frame_mover #(
    parameter int          ADDR_W = 11,
    parameter logic [15:0] MAGIC  = 16'hA55A
) (
    input  logic              pheriphal_clk_clk,
    input  logic              pheriphal_reset_reset,
    input  logic              rx_ready,
    output logic              rx_release,
    output logic              irq,
    input  logic              irq_clr,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] frame_len,
    output logic [ADDR_W-1:0] usb_rx_ram_s1_address,
    output logic              usb_rx_ram_s1_chipselect,
    output logic              usb_rx_ram_s1_clken,
    output logic              usb_rx_ram_s1_write,
    input  logic [31:0]       usb_rx_ram_s1_readdata,
    output logic [ADDR_W-1:0] usb_data_ram_s2_address,
    output logic              usb_data_ram_s2_chipselect,
    output logic              usb_data_ram_s2_clken,
    output logic              usb_data_ram_s2_write,
    output logic [31:0]       usb_data_ram_s2_writedata,
    output logic [3:0]        usb_data_ram_s2_byteenable
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DECODE, S_COPY,
`ifdef USB_FRAME_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE, S_WAIT_LOW
    } state_t;

    localparam logic [ADDR_W-1:0] ALL1 = '1;
`ifdef USB_FRAME_CHECKSUM_EN
    localparam logic [ADDR_W-1:0] N_MAX = ALL1 - ADDR_W'(2);
`else
    localparam logic [ADDR_W-1:0] N_MAX = ALL1 - ADDR_W'(1);
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              ferr_q, ferr_d;
    logic              irq_q, irq_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] frame_len_q, frame_len_d;
`ifdef USB_FRAME_CHECKSUM_EN
    logic [31:0]       sum_q, sum_d;
`endif
    logic              rd_en, wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] hdr_len;
    logic [ADDR_W:0]   kp1, kp2;

    assign hdr_len = usb_rx_ram_s1_readdata[ADDR_W-1:0];
    assign kp1     = {1'b0, k_q} + (ADDR_W+1)'(1);
    assign kp2     = {1'b0, k_q} + (ADDR_W+1)'(2);

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        k_d         = k_q;
        ferr_d      = ferr_q;
        irq_d       = irq_q & ~irq_clr;
        err_d       = err_q & ~irq_clr;
        frame_len_d = frame_len_q;
`ifdef USB_FRAME_CHECKSUM_EN
        sum_d       = sum_q;
`endif
        rd_en       = 1'b0;
        rd_addr     = '0;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE: if (rx_ready) state_d = S_HDR;
            S_HDR: begin
                rd_en   = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                len_d  = hdr_len;
                k_d    = '0;
                ferr_d = 1'b0;
`ifdef USB_FRAME_CHECKSUM_EN
                sum_d  = '0;
`endif
                if (usb_rx_ram_s1_readdata[31:16] != MAGIC || hdr_len > N_MAX) begin
                    ferr_d  = 1'b1;
                    state_d = S_DONE;
                end else if (hdr_len == '0) begin
`ifdef USB_FRAME_CHECKSUM_EN
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(1);
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = ADDR_W'(1);
                    state_d = S_COPY;
                end
            end
            S_COPY: begin
                wr_en = 1'b1;
                k_d   = kp1[ADDR_W-1:0];
`ifdef USB_FRAME_CHECKSUM_EN
                sum_d = sum_q + usb_rx_ram_s1_readdata;
                // Prefetch runs one word past the payload to fetch the checksum.
                if (kp2 <= {1'b0, len_q} + (ADDR_W+1)'(1)) begin
`else
                if (kp2 <= {1'b0, len_q}) begin
`endif
                    rd_en   = 1'b1;
                    rd_addr = kp2[ADDR_W-1:0];
                end
                if (kp1 == {1'b0, len_q}) begin
`ifdef USB_FRAME_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef USB_FRAME_CHECKSUM_EN
            S_CHK: begin
                if (usb_rx_ram_s1_readdata != sum_q) ferr_d = 1'b1;
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                // Set wins over a same-cycle irq_clr; err reflects this frame only.
                irq_d = 1'b1;
                err_d = ferr_q;
                if (!ferr_q) frame_len_d = len_q;
                state_d = S_WAIT_LOW;
            end
            S_WAIT_LOW: if (!rx_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pheriphal_clk_clk or posedge pheriphal_reset_reset) begin
        if (pheriphal_reset_reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            k_q         <= '0;
            ferr_q      <= 1'b0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
            frame_len_q <= '0;
`ifdef USB_FRAME_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            k_q         <= k_d;
            ferr_q      <= ferr_d;
            irq_q       <= irq_d;
            err_q       <= err_d;
            frame_len_q <= frame_len_d;
`ifdef USB_FRAME_CHECKSUM_EN
            sum_q       <= sum_d;
`endif
        end
    end

    assign rx_release                 = (state_q == S_DONE);
    assign busy                       = (state_q != S_IDLE) && (state_q != S_WAIT_LOW);
    assign irq                        = irq_q;
    assign err                        = err_q;
    assign frame_len                  = frame_len_q;
    assign usb_rx_ram_s1_address      = rd_addr;
    assign usb_rx_ram_s1_chipselect   = rd_en;
    assign usb_rx_ram_s1_clken        = rd_en;
    assign usb_rx_ram_s1_write        = 1'b0;
    assign usb_data_ram_s2_address    = wr_en ? k_q : '0;
    assign usb_data_ram_s2_chipselect = wr_en;
    assign usb_data_ram_s2_clken      = wr_en;
    assign usb_data_ram_s2_write      = wr_en;
    assign usb_data_ram_s2_writedata  = wr_en ? usb_rx_ram_s1_readdata : '0;
    assign usb_data_ram_s2_byteenable = wr_en ? 4'hF : 4'h0;
endmodule

// File: tb/tb_usb_rx_frame_mover.sv
// Scoreboard bench for usb_rx_frame_mover: stimulus pushes expected writes/releases, a negedge monitor pops and compares.
module tb_usb_rx_frame_mover;
    localparam int ADDR_W = 11;
`ifdef USB_FRAME_CHECKSUM_EN
    localparam int CK = 1;
    localparam int NMAX = 2045;
`else
    localparam int CK = 0;
    localparam int NMAX = 2046;
`endif

    logic clk = 1'b0, rst = 1'b1, rx_ready = 1'b0, irq_clr = 1'b0;
    logic rx_release, irq, busy, err;
    logic [ADDR_W-1:0] frame_len, rx_addr, d_addr;
    logic rx_cs, rx_ce, rx_we, d_cs, d_ce, d_we;
    logic [31:0] rx_rdata = '0, d_wdata;
    logic [3:0] d_be;

    logic [31:0] rxmem [0:2047];
    logic [31:0] dmem [0:2047];

    typedef struct { int addr; logic [31:0] data; int cyc; } wr_t;
    wr_t wq[$];
    int  rq[$];
    wr_t we_exp;
    int  rel_exp;
    int  cyc = 0, n_chk = 0, n_fail = 0, exp_len = 0;

    usb_rx_frame_mover #(.ADDR_W(ADDR_W), .MAGIC(16'hA55A)) dut (
        .pheriphal_clk_clk(clk), .pheriphal_reset_reset(rst),
        .rx_ready(rx_ready), .rx_release(rx_release), .irq(irq), .irq_clr(irq_clr),
        .busy(busy), .err(err), .frame_len(frame_len),
        .usb_rx_ram_s1_address(rx_addr), .usb_rx_ram_s1_chipselect(rx_cs),
        .usb_rx_ram_s1_clken(rx_ce), .usb_rx_ram_s1_write(rx_we),
        .usb_rx_ram_s1_readdata(rx_rdata),
        .usb_data_ram_s2_address(d_addr), .usb_data_ram_s2_chipselect(d_cs),
        .usb_data_ram_s2_clken(d_ce), .usb_data_ram_s2_write(d_we),
        .usb_data_ram_s2_writedata(d_wdata), .usb_data_ram_s2_byteenable(d_be)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models: one-cycle read latency on RX, write capture on data RAM.
    always @(posedge clk) begin
        if (rx_cs && rx_ce) rx_rdata <= rxmem[rx_addr];
        if (d_cs && d_ce && d_we) dmem[d_addr] <= d_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (d_cs) begin
                if (wq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %h at cycle %0d, none expected", d_addr, d_wdata, cyc);
                end else begin
                    we_exp = wq.pop_front();
                    check("wr_addr", 32'(d_addr), we_exp.addr);
                    check("wr_data", d_wdata, we_exp.data);
                    check("wr_cycle", cyc, we_exp.cyc);
                    check("wr_strobes", {d_ce, d_we, d_be}, 6'h3F);
                end
            end
            if (rx_release) begin
                if (rq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_release at cycle %0d, none expected", cyc);
                end else begin
                    rel_exp = rq.pop_front();
                    check("release_cycle", cyc, rel_exp);
                end
            end
        end
    end

    task automatic frame(input logic [31:0] hdr, input int mul, input bit bad_ck, input int hold);
        int n, t;
        bit ok, exp_err;
        logic [31:0] s;
        wr_t w;
        n  = int'(hdr[10:0]);
        ok = (hdr[31:16] == 16'hA55A) && (n <= NMAX);
        s  = '0;
        rxmem[0] = hdr;
        for (int i = 0; i < n; i++) begin
            rxmem[i+1] = 32'(mul * (i + 1));
            s += 32'(mul * (i + 1));
        end
        if (n + 1 < 2048) rxmem[n+1] = s + 32'(bad_ck);
        @(posedge clk); #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        check("irq_cleared", irq, 1'b0);
        check("err_cleared", err, 1'b0);
        rx_ready = 1'b1;
        t = cyc;
        if (ok) begin
            for (int i = 0; i < n; i++) begin
                w.addr = i; w.data = 32'(mul * (i + 1)); w.cyc = t + 3 + i;
                wq.push_back(w);
            end
            rq.push_back(t + n + 3 + CK);
            exp_err = bad_ck && (CK == 1);
            if (!exp_err) exp_len = n;
        end else begin
            rq.push_back(t + 3);
            exp_err = 1'b1;
        end
        repeat ((ok ? n : 0) + 6 + hold) @(posedge clk);
        #1;
        check("irq_set", irq, 1'b1);
        check("err", err, exp_err);
        check("frame_len", 32'(frame_len), exp_len);
        check("busy_after", busy, 1'b0);
        rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t2;
        wr_t w;
        for (int i = 0; i < 2048; i++) begin rxmem[i] = '0; dmem[i] = '0; end
        @(posedge clk); #1;
        check("rst_release", rx_release, 1'b0);
        check("rst_irq", irq, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_frame_len", 32'(frame_len), 0);
        check("rst_busy", busy, 1'b0);
        check("rst_strobes", {rx_cs, rx_ce, rx_we, d_cs, d_ce, d_we, d_be}, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 4-word frame with rx_ready held long after: one release only.
        frame(32'hA55A0004, 32'h11, 1'b0, 50);
        for (int i = 0; i < 4; i++) check("dmem_f1", dmem[i], 32'(32'h11 * (i + 1)));
        frame(32'h12340004, 32'h7, 1'b0, 0);
        frame(32'hA55A07FF, 32'h3, 1'b0, 0);
        frame(32'hA55A0000, 32'h5, 1'b0, 0);

        // Reset in the third write of an 8-word frame.
        for (int i = 0; i < 8; i++) dmem[i] = '0;
        rxmem[0] = 32'hA55A0008;
        for (int i = 0; i < 8; i++) rxmem[i+1] = 32'(32'h100 * (i + 1));
        rxmem[9] = 32'h2400;
        @(posedge clk); #1 rx_ready = 1'b1;
        t2 = cyc;
        for (int i = 0; i < 3; i++) begin
            w.addr = i; w.data = 32'(32'h100 * (i + 1)); w.cyc = t2 + 3 + i;
            wq.push_back(w);
        end
        while (cyc < t2 + 5) begin @(posedge clk); #1; end
        #6 rst = 1'b1;
        #1;
        check("rst_mid_dwr", {d_cs, d_ce, d_we, d_be}, '0);
        check("rst_mid_rd", {rx_cs, rx_ce}, '0);
        check("rst_mid_release", rx_release, 1'b0);
        check("rst_mid_irq", irq, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        exp_len = 0;
        t2 = cyc;
        for (int i = 0; i < 8; i++) begin
            w.addr = i; w.data = 32'(32'h100 * (i + 1)); w.cyc = t2 + 3 + i;
            wq.push_back(w);
        end
        rq.push_back(t2 + 11 + CK);
        repeat (16) @(posedge clk);
        #1;
        check("rerun_irq", irq, 1'b1);
        check("rerun_len", 32'(frame_len), 8);
        for (int i = 0; i < 8; i++) check("dmem_rerun", dmem[i], 32'(32'h100 * (i + 1)));
        exp_len = 8;
        rx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 irq_clr = 1'b1;
        @(posedge clk); #1 irq_clr = 1'b0;
        check("irq_clr", irq, 1'b0);

`ifdef USB_FRAME_CHECKSUM_EN
        frame(32'hA55A0002, 1, 1'b0, 0);
        for (int i = 0; i < 2; i++) dmem[i] = '0;
        frame(32'hA55A0002, 1, 1'b1, 0);
        check("dmem_ck0", dmem[0], 32'd1);
        check("dmem_ck1", dmem[1], 32'd2);
`endif

        repeat (4) @(posedge clk);
        check("wq_drained", wq.size(), 0);
        check("rq_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
